// File: rtl/sys_gpio_mm_initiator.sv
// sys_gpio_mm_initiator: Avalon-MM initiator that sequences queued register
// commands onto a PIO-style GPIO responder and returns read data.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready             command push handshake into the FIFO
//   cmd_write, cmd_addr, cmd_wdata  command fields (1 = write, 0 = read)
//   rsp_valid, rsp_data             one-cycle read-response pulse, data held
//   busy                            FIFO non-empty or bus transaction active
//   avm_*                           registered Avalon-MM initiator signals
//   gpio_irq                        responder interrupt input
//   evt_valid, evt_data             IRQ-service event pulse and snapshot
//
// Optional feature macro: SYS_GPIO_IRQ_SVC_EN. When defined, a pending
// gpio_irq in IDLE pre-empts the FIFO: read address 0, report it on evt_*,
// then write 0 to the IRQ mask at address 2. When undefined, gpio_irq is
// ignored and evt_* are tied to 0.
module sys_gpio_mm_initiator #(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              gpio_irq,
    output logic              evt_valid,
    output logic [DATA_W-1:0] evt_data
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + ADDR_W + DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_WAIT
`ifdef SYS_GPIO_IRQ_SVC_EN
        , SVC_RD,
        SVC_WAIT,
        SVC_WR
`endif
    } state_t;

    state_t          state;
    logic [EW-1:0]   fifo [FIFO_DEPTH];
    logic [EW-1:0]   head;
    logic [PW:0]     wptr, rptr;
    logic            empty, full, push, pop, svc_req, rd_done;
    logic [1:0]      cnt;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty     = wptr == rptr;
    assign full      = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == IDLE) && !empty && !svc_req;
    assign head      = fifo[rptr[PW-1:0]];
    assign busy      = !empty || (state != IDLE);
    assign rd_done   = cnt == 2'(RD_LATENCY - 1);

`ifdef SYS_GPIO_IRQ_SVC_EN
    assign svc_req = gpio_irq;
`else
    logic unused_irq;
    assign svc_req    = 1'b0;
    assign unused_irq = gpio_irq;
    assign evt_valid  = 1'b0;
    assign evt_data   = '0;
`endif

    always_ff @(posedge clk) begin
        if (push) fifo[wptr[PW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wptr           <= '0;
            rptr           <= '0;
            cnt            <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
`ifdef SYS_GPIO_IRQ_SVC_EN
            evt_valid      <= 1'b0;
            evt_data       <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef SYS_GPIO_IRQ_SVC_EN
            evt_valid <= 1'b0;
`endif
            if (push) wptr <= wptr + (PW+1)'(1);
            if (pop) rptr <= rptr + (PW+1)'(1);
            case (state)
                IDLE: begin
                    if (svc_req) begin
`ifdef SYS_GPIO_IRQ_SVC_EN
                        avm_address    <= '0;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b1;
                        cnt            <= '0;
                        state          <= SVC_RD;
`endif
                    end else if (!empty) begin
                        avm_address    <= head[EW-2:DATA_W];
                        avm_writedata  <= head[DATA_W-1:0];
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= !head[EW-1];
                        cnt            <= '0;
                        state          <= head[EW-1] ? WR : RD_ADDR;
                    end
                end
                WR: begin
                    avm_chipselect <= 1'b0;
                    avm_write_n    <= 1'b1;
                    state          <= IDLE;
                end
                RD_ADDR: begin
                    avm_chipselect <= 1'b0;
                    state          <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (rd_done) begin
                        rsp_data  <= avm_readdata;
                        rsp_valid <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
`ifdef SYS_GPIO_IRQ_SVC_EN
                SVC_RD: begin
                    avm_chipselect <= 1'b0;
                    state          <= SVC_WAIT;
                end
                // Snapshot and mask write are issued on the same edge.
                SVC_WAIT: begin
                    if (rd_done) begin
                        evt_data       <= avm_readdata;
                        evt_valid      <= 1'b1;
                        avm_address    <= ADDR_W'(2);
                        avm_writedata  <= '0;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        state          <= SVC_WR;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                SVC_WR: begin
                    avm_chipselect <= 1'b0;
                    avm_write_n    <= 1'b1;
                    state          <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sys_gpio_mm_initiator.sv
// tb_sys_gpio_mm_initiator: scoreboard bench for sys_gpio_mm_initiator with
// a register-file responder; instance a uses RD_LATENCY=1, instance b uses 3.
module tb_sys_gpio_mm_initiator;
    typedef struct packed {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;

    logic        cmd_valid_a = 1'b0, rdy_a, rsp_valid_a, busy_a, cs_a, wn_a, irq_a, evt_valid_a;
    logic [31:0] rsp_data_a, wd_a, evt_data_a;
    logic [31:0] rd_a = '0;
    logic [1:0]  addr_a;
    logic [31:0] mem_a [4] = '{default: 0};

    logic        cmd_valid_b = 1'b0, rdy_b, rsp_valid_b, busy_b, cs_b, wn_b, irq_b, evt_valid_b;
    logic [31:0] rsp_data_b, wd_b, evt_data_b, rd_b;
    logic [1:0]  addr_b;
    logic [31:0] mem_b [4] = '{default: 0};
    logic [31:0] p_b [3] = '{default: 0};

    bus_t        bus_q [$];
    logic [31:0] rsp_q_a [$];
    logic [31:0] rsp_q_b [$];
    logic [31:0] evt_q [$];
    bus_t        e_a;
    logic [31:0] x_a, x_b;
    int          rd_cyc_a = 0, rd_cyc_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sys_gpio_mm_initiator #(.RD_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(rdy_a),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .busy(busy_a),
        .avm_address(addr_a), .avm_chipselect(cs_a), .avm_write_n(wn_a),
        .avm_writedata(wd_a), .avm_readdata(rd_a), .gpio_irq(irq_a),
        .evt_valid(evt_valid_a), .evt_data(evt_data_a)
    );

    sys_gpio_mm_initiator #(.RD_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(rdy_b),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .busy(busy_b),
        .avm_address(addr_b), .avm_chipselect(cs_b), .avm_write_n(wn_b),
        .avm_writedata(wd_b), .avm_readdata(rd_b), .gpio_irq(irq_b),
        .evt_valid(evt_valid_b), .evt_data(evt_data_b)
    );

    // Responders: register file, readdata registered through RD_LATENCY stages.
    always @(posedge clk) begin
        if (cs_a && !wn_a) mem_a[addr_a] <= wd_a;
        rd_a <= mem_a[addr_a];
    end
    assign irq_a = |(mem_a[0] & mem_a[2]);

    always @(posedge clk) begin
        if (cs_b && !wn_b) mem_b[addr_b] <= wd_b;
        p_b[0] <= mem_b[addr_b];
        p_b[1] <= p_b[0];
        p_b[2] <= p_b[1];
    end
    assign rd_b  = p_b[2];
    assign irq_b = |(mem_b[0] & mem_b[2]);

    // Monitors: pop expectations whenever a DUT presents bus, rsp or evt activity.
    always @(negedge clk) begin
        if (!reset) begin
            if (cs_a) begin
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_a: unexpected we=%0d addr=%0d data=%h, required no access", !wn_a, addr_a, wd_a);
                end else begin
                    e_a = bus_q.pop_front();
                    if (e_a.we != !wn_a || e_a.addr != addr_a || (e_a.we && e_a.data != wd_a)) begin
                        errors++;
                        $display("FAIL bus_a: got we=%0d addr=%0d data=%h, required we=%0d addr=%0d data=%h",
                                 !wn_a, addr_a, wd_a, e_a.we, e_a.addr, e_a.data);
                    end
                end
                if (wn_a) rd_cyc_a = cyc;
            end
            if (rsp_valid_a) begin
                checks++;
                if (rsp_q_a.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_a: unexpected data=%h, required no response", rsp_data_a);
                end else begin
                    x_a = rsp_q_a.pop_front();
                    if (rsp_data_a != x_a || cyc - rd_cyc_a != 2) begin
                        errors++;
                        $display("FAIL rsp_a: got data=%h lat=%0d, required data=%h lat=2", rsp_data_a, cyc - rd_cyc_a, x_a);
                    end
                end
            end
            if (evt_valid_a) begin
                checks++;
`ifdef SYS_GPIO_IRQ_SVC_EN
                if (evt_q.size() == 0) begin
                    errors++;
                    $display("FAIL evt_a: unexpected data=%h, required no event", evt_data_a);
                end else begin
                    x_a = evt_q.pop_front();
                    if (evt_data_a != x_a) begin
                        errors++;
                        $display("FAIL evt_a: got data=%h, required %h", evt_data_a, x_a);
                    end
                end
`else
                errors++;
                $display("FAIL evt_a: got evt_valid=1, required 0");
`endif
            end
            if (cs_b && wn_b) rd_cyc_b = cyc;
            if (rsp_valid_b) begin
                checks++;
                if (rsp_q_b.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_b: unexpected data=%h, required no response", rsp_data_b);
                end else begin
                    x_b = rsp_q_b.pop_front();
                    if (rsp_data_b != x_b || cyc - rd_cyc_b != 4) begin
                        errors++;
                        $display("FAIL rsp_b: got data=%h lat=%0d, required data=%h lat=4", rsp_data_b, cyc - rd_cyc_b, x_b);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic exp_bus(input logic we, input logic [1:0] a, input logic [31:0] d);
        bus_q.push_back(bus_t'{we: we, addr: a, data: d});
    endtask

    task automatic push(input int k, input logic we, input logic [1:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rsp, input bit track);
        int n;
        n = 0;
        cmd_write = we;
        cmd_addr  = a;
        cmd_wdata = d;
        if (k == 0) cmd_valid_a = 1'b1;
        else cmd_valid_b = 1'b1;
        while (((k == 0) ? !rdy_a : !rdy_b) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles, required 1", n);
        end
        if (track) begin
            if (k == 0) exp_bus(we, a, d);
            if (!we && k == 0) rsp_q_a.push_back(exp_rsp);
            if (!we && k != 0) rsp_q_b.push_back(exp_rsp);
        end
        @(posedge clk);
        #1;
        cmd_valid_a = 1'b0;
        cmd_valid_b = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (((k == 0) ? busy_a : busy_b) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", (k == 0) ? busy_a : busy_b, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl_a", {rdy_a, rsp_valid_a, busy_a, cs_a, wn_a, evt_valid_a}, 6'b100010);
        chk("rst_data_a", {rsp_data_a, wd_a}, 64'h0);
        chk("rst_misc_a", {addr_a, evt_data_a}, 34'h0);
        chk("rst_ctl_b", {rdy_b, busy_b, cs_b, wn_b}, 4'b1001);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single write: one bus cycle, busy falls two edges after the push.
        push(0, 1'b1, 2'd0, 32'hA5A5_0001, 32'h0, 1'b1);
        chk("busy_after_push", busy_a, 1);
        @(posedge clk);
        #1;
        chk("busy_in_wr", busy_a, 1);
        @(posedge clk);
        #1;
        chk("busy_fall", busy_a, 0);
        chk("mem0_written", mem_a[0], 32'hA5A5_0001);

        // Write then read of the same register observes the new value.
        push(0, 1'b1, 2'd0, 32'h0000_00FF, 32'h0, 1'b1);
        push(0, 1'b0, 2'd0, 32'h0, 32'h0000_00FF, 1'b1);
        wait_idle(0);

        // Back-to-back burst stalled behind reads fills the FIFO.
        push(0, 1'b0, 2'd0, 32'h0, 32'h0000_00FF, 1'b1);
        push(0, 1'b0, 2'd1, 32'h0, 32'h0, 1'b1);
        push(0, 1'b1, 2'd1, 32'h11, 32'h0, 1'b1);
        push(0, 1'b1, 2'd3, 32'h33, 32'h0, 1'b1);
        push(0, 1'b1, 2'd1, 32'h111, 32'h0, 1'b1);
        push(0, 1'b1, 2'd3, 32'h333, 32'h0, 1'b1);
        chk("full_ready_low", rdy_a, 0);
        push(0, 1'b0, 2'd1, 32'h0, 32'h111, 1'b1);
        wait_idle(0);
        chk("mem3_order", mem_a[3], 32'h333);

        // Reset during RD_WAIT with two commands queued.
        push(0, 1'b0, 2'd0, 32'h0, 32'h0000_00FF, 1'b1);
        push(0, 1'b1, 2'd1, 32'h5, 32'h0, 1'b1);
        push(0, 1'b1, 2'd3, 32'h6, 32'h0, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_mid_ctl", {cs_a, wn_a, busy_a, rsp_valid_a, rdy_a}, 5'b01001);
        bus_q.delete();
        rsp_q_a.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mid_busy", busy_a, 0);
        chk("rst_mid_discard", {mem_a[1], mem_a[3]}, {32'h111, 32'h333});

        // IRQ raised by mask write while another write is queued.
        exp_bus(1'b1, 2'd0, 32'h1);
        exp_bus(1'b1, 2'd2, 32'h1);
`ifdef SYS_GPIO_IRQ_SVC_EN
        exp_bus(1'b0, 2'd0, 32'h0);
        exp_bus(1'b1, 2'd2, 32'h0);
        evt_q.push_back(32'h1);
`endif
        exp_bus(1'b1, 2'd1, 32'hBEEF);
        push(0, 1'b1, 2'd0, 32'h1, 32'h0, 1'b0);
        push(0, 1'b1, 2'd2, 32'h1, 32'h0, 1'b0);
        push(0, 1'b1, 2'd1, 32'hBEEF, 32'h0, 1'b0);
        wait_idle(0);
`ifdef SYS_GPIO_IRQ_SVC_EN
        push(0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1);
`else
        push(0, 1'b0, 2'd2, 32'h0, 32'h1, 1'b1);
`endif
        wait_idle(0);

        // RD_LATENCY=3 instance: read mask register back.
        push(1, 1'b1, 2'd2, 32'h0000_0F0F, 32'h0, 1'b1);
        push(1, 1'b0, 2'd2, 32'h0, 32'h0000_0F0F, 1'b1);
        wait_idle(1);

        repeat (3) @(negedge clk);
`ifdef SYS_GPIO_IRQ_SVC_EN
        chk("evt_data_final", evt_data_a, 32'h1);
`else
        chk("evt_data_final", evt_data_a, 32'h0);
`endif
        chk("bus_q_drained", 64'(bus_q.size()), 0);
        chk("rsp_q_a_drained", 64'(rsp_q_a.size()), 0);
        chk("rsp_q_b_drained", 64'(rsp_q_b.size()), 0);
        chk("evt_q_drained", 64'(evt_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
